// File: rtl/sram_arbiter.sv
// Single-port async SRAM arbiter for video, CPU and DMA masters.
// Video has fixed priority; CPU/DMA share round-robin with a starvation override.
module sram_arbiter #(
  parameter int unsigned AW           = 14,
  parameter int unsigned DW           = 16,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic          clk_core,
  input  logic          core_reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_rvalid,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] sram_a,
  output logic          sram_wr,
  output logic [DW-1:0] host_to_sram,
  input  logic [DW-1:0] sram_to_host
);

  localparam int unsigned CW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU, TAG_DMA} tag_e;
  typedef enum logic {RR_CPU, RR_DMA} rr_e;

  rr_e                          rr_q, rr_d;
  logic [CW-1:0]                cpu_cnt_q, cpu_cnt_d;
  logic [CW-1:0]                dma_cnt_q, dma_cnt_d;
  logic                         cpu_starved, dma_starved;

  logic [AW-1:0]                sram_a_d;
  logic                         sram_wr_d;
  logic [DW-1:0]                host_to_sram_d;
  tag_e                         tag_d;
  logic [RD_LATENCY-1:0][1:0]   tag_pipe_q, tag_pipe_d;
  logic [1:0]                   tag_out;
  logic [DW-1:0]                rdata_d;
  logic                         vid_rvalid_d, cpu_rvalid_d, dma_rvalid_d;

  // A saturated counter means the port has waited long enough to beat video.
  assign cpu_starved = (STARVE_LIMIT != 0) && cpu_req && (cpu_cnt_q == CW'(STARVE_LIMIT));
  assign dma_starved = (STARVE_LIMIT != 0) && dma_req && (dma_cnt_q == CW'(STARVE_LIMIT));

  // Grant selection
  always_comb begin
    vid_gnt = 1'b0;
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (cpu_starved && dma_starved) begin
      if (rr_q == RR_CPU) cpu_gnt = 1'b1;
      else                dma_gnt = 1'b1;
    end else if (cpu_starved) begin
      cpu_gnt = 1'b1;
    end else if (dma_starved) begin
      dma_gnt = 1'b1;
    end else if (vid_req) begin
      vid_gnt = 1'b1;
    end else if (cpu_req && dma_req) begin
      if (rr_q == RR_CPU) cpu_gnt = 1'b1;
      else                dma_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (dma_req) begin
      dma_gnt = 1'b1;
    end
  end

  // Round-robin pointer and starvation counters, next state
  always_comb begin
    rr_d      = rr_q;
    cpu_cnt_d = '0;
    dma_cnt_d = '0;
    if (cpu_gnt)      rr_d = RR_DMA;
    else if (dma_gnt) rr_d = RR_CPU;
    if (cpu_req && !cpu_gnt) begin
      cpu_cnt_d = (cpu_cnt_q == CW'(STARVE_LIMIT)) ? cpu_cnt_q : cpu_cnt_q + CW'(1);
    end
    if (dma_req && !dma_gnt) begin
      dma_cnt_d = (dma_cnt_q == CW'(STARVE_LIMIT)) ? dma_cnt_q : dma_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      rr_q      <= RR_CPU;
      cpu_cnt_q <= '0;
      dma_cnt_q <= '0;
    end else begin
      rr_q      <= rr_d;
      cpu_cnt_q <= cpu_cnt_d;
      dma_cnt_q <= dma_cnt_d;
    end
  end

  // Issue mux: address/data hold when idle so the pads do not toggle.
  always_comb begin
    sram_a_d       = sram_a;
    sram_wr_d      = 1'b0;
    host_to_sram_d = host_to_sram;
    tag_d          = TAG_NONE;
    if (vid_gnt) begin
      sram_a_d = vid_addr;
      tag_d    = TAG_VID;
    end else if (cpu_gnt) begin
      sram_a_d       = cpu_addr;
      sram_wr_d      = cpu_wr;
      host_to_sram_d = cpu_wdata;
      tag_d          = cpu_wr ? TAG_NONE : TAG_CPU;
    end else if (dma_gnt) begin
      sram_a_d       = dma_addr;
      sram_wr_d      = dma_wr;
      host_to_sram_d = dma_wdata;
      tag_d          = dma_wr ? TAG_NONE : TAG_DMA;
    end
  end

  // Read-tag shift pipeline; the last stage marks the capture edge.
  always_comb begin
    tag_pipe_d    = tag_pipe_q;
    tag_pipe_d[0] = tag_d;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
  end

  assign tag_out = tag_pipe_q[RD_LATENCY-1];

  always_comb begin
    rdata_d      = rdata;
    vid_rvalid_d = 1'b0;
    cpu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    if (tag_out != TAG_NONE) rdata_d = sram_to_host;
    if (tag_out == TAG_VID)  vid_rvalid_d = 1'b1;
    if (tag_out == TAG_CPU)  cpu_rvalid_d = 1'b1;
    if (tag_out == TAG_DMA)  dma_rvalid_d = 1'b1;
  end

  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      sram_a       <= '0;
      sram_wr      <= 1'b0;
      host_to_sram <= '0;
      tag_pipe_q   <= '0;
      rdata        <= '0;
      vid_rvalid   <= 1'b0;
      cpu_rvalid   <= 1'b0;
      dma_rvalid   <= 1'b0;
    end else begin
      sram_a       <= sram_a_d;
      sram_wr      <= sram_wr_d;
      host_to_sram <= host_to_sram_d;
      tag_pipe_q   <= tag_pipe_d;
      rdata        <= rdata_d;
      vid_rvalid   <= vid_rvalid_d;
      cpu_rvalid   <= cpu_rvalid_d;
      dma_rvalid   <= dma_rvalid_d;
    end
  end

endmodule
